alu_sched: RTL and testbench
============================

# alu_sched

Two-port scheduler that shares one combinational `alu` instance between two requesters. It arbitrates round-robin, holds the ALU operands stable for an opcode-dependent number of cycles, and captures the result. It returns a one-cycle response to the granted requester, and it traps divide-by-zero and illegal opcodes without exercising the ALU. It sits between the issue logic and the shared ALU datapath.

## Interface
- `MUL_CYCLES`, default 2: EXEC cycles for MUL (≥1).
- `DIV_CYCLES`, default 4: EXEC cycles for DIV (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_opcode` in 4, `req0_a` in 8, `req0_b` in 8: operation and operands.
- `rsp0_valid` out 1: one-cycle response pulse to requester 0.
- `rsp0_y` out 8, `rsp0_zero` out 1, `rsp0_ovf` out 1, `rsp0_err` out 1: response fields.
- `req1_*` and `rsp1_*`: identical set for requester 1.
- `alu_opcode` out 4, `alu_a` out 8, `alu_b` out 8: drive the shared ALU.
- `alu_y` in 8, `alu_zero` in 1, `alu_overflow` in 1: ALU results.

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - If any `reqN_valid` is high, grant one requester and assert its `reqN_ready` combinationally in the same cycle.
  - On that edge, latch opcode, a and b into op registers and go to EXEC.
- Round-robin rule:
  - When both requesters are valid, grant the one not granted last.
  - When only one is valid, grant it.
  - The pointer updates only on a grant.
  - After reset, requester 0 wins the first tie.
- `reqN_ready` is low in EXEC and for the non-granted requester.
- EXEC:
  - Drive `alu_*` from the op registers.
  - Load a down-counter with L−1 on entry.
  - L = 1 for opcodes 0x0, 0x1 and 0x4–0x9; L = MUL_CYCLES for 0x2; L = DIV_CYCLES for 0x3.
  - When the counter reaches 0, register `alu_y`, `alu_zero` and `alu_overflow` into the granted requester's response registers, set `rspN_valid`, set `rspN_err`=0, and return to IDLE.
- Trapped ops: for opcode 0x3 with b==0, or any opcode ≥ 0xA, the EXEC state lasts one cycle and ignores ALU inputs.
  - Divide-by-zero response: y=8'hFF, zero=0, ovf=0, err=1.
  - Illegal-opcode response: y=8'h00, zero=1, ovf=0, err=1.
- Outside EXEC, `alu_opcode`=4'hF and `alu_a`=`alu_b`=0 (ALU default path, y=0).
- Response handling:
  - `rspN_valid` is a one-cycle pulse with no backpressure.
  - `rspN_y/zero/ovf/err` hold their values until the next response to that port.
  - At most one `rspN_valid` is high per cycle.
- Reset values: all `rsp*` 0, `req*_ready` 0, `alu_opcode` 4'hF, `alu_a`/`alu_b` 0, state IDLE, RR pointer favours requester 0.
- Reset asserted mid-EXEC drops the in-flight op with no response.

## Timing
- Accept at edge E0 (valid & ready): EXEC spans E0..E_L, result registered at E_L, `rspN_valid` high E_L..E_L+1.
- The FSM is back in IDLE during the response cycle, so the next accept can occur at E_L+1. Throughput is one op per L+1 cycles.
- Requester inputs are sampled only at the accepting edge; later changes do not affect the in-flight op.
- `alu_*` are stable for all L EXEC cycles.
- A trapped op has L=1 regardless of opcode.
- `req*_ready` depends combinationally on `req*_valid` and state only, never on `rsp*` signals.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD=0 … OP_SHR=9, OP_NOP=4'hF.
  - state enum.
  - trap result constants Y_DIV0=8'hFF, Y_ILL=8'h00.
- The latency decode from opcode belongs in the package as a function.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with grant-update enable. The FSM, counter, op registers and response registers stay in `alu_sched`.

## Test plan
- Req0 only, ADD a=0x70 b=0x20 accepted at E0 → `alu_opcode`=0 during E0..E1; `rsp0_valid` pulse after E1 with y=0x90, err=0; `req0_ready` low during EXEC.
- Both valid, continuously issuing from reset → grants alternate 0,1,0,1; `rsp0_valid` and `rsp1_valid` never high together.
- DIV a=200 b=7 with DIV_CYCLES=4 → `alu_*` stable 4 cycles; response y=28 at E4; next accept no earlier than E5.
- DIV a=9 b=0 → no ALU activity (`alu_opcode` stays 0xF); one-cycle response y=0xFF, err=1. Opcode 0xC → y=0x00, zero=1, err=1.
- MUL in EXEC, `rst_n` pulsed low at E1 → all outputs go to reset values immediately; no `rsp` pulse; next request proceeds normally with requester 0 winning the tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, state and trap definitions for the ALU scheduler.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam logic [7:0] Y_DIV0 = 8'hFF;
  localparam logic [7:0] Y_ILL  = 8'h00;

  typedef enum logic {StIdle, StExec} state_e;

  typedef enum logic [1:0] {TrapNone, TrapDiv0, TrapIll} trap_e;

  // Number of EXEC cycles an untrapped opcode holds the ALU operands.
  function automatic logic [7:0] op_latency(input logic [3:0] op, input logic [7:0] mul_cycles,
                                            input logic [7:0] div_cycles);
    logic [7:0] lat;
    case (op)
      OP_MUL:  lat = mul_cycles;
      OP_DIV:  lat = div_cycles;
      default: lat = 8'd1;
    endcase
    return lat;
  endfunction

  // Classify ops that must not reach the ALU.
  function automatic trap_e op_trap(input logic [3:0] op, input logic [7:0] b);
    trap_e t;
    if (op >= 4'hA) begin
      t = TrapIll;
    end else if (op == OP_DIV && b == 8'h00) begin
      t = TrapDiv0;
    end else begin
      t = TrapNone;
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer advances only when en_i accepts a grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Index of the requester granted most recently; reset value lets requester 0 win the first tie.
  logic last_q;

  // Grant the lone requester, or on a tie the one not granted last.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Remember the winner of each accepted grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (en_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between two requesters with round-robin arbitration,
// opcode-dependent hold time and trapping of divide-by-zero / illegal opcodes.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_opcode,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_y,
  output logic       rsp0_zero,
  output logic       rsp0_ovf,
  output logic       rsp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_opcode,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_y,
  output logic       rsp1_zero,
  output logic       rsp1_ovf,
  output logic       rsp1_err,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  input  logic       alu_zero,
  input  logic       alu_overflow
);

  state_e     state_q;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       port_q;
  trap_e      trap_q;
  logic [7:0] cnt_q;

  logic [1:0] gnt;
  logic       idle, accept;
  logic [3:0] in_op;
  logic [7:0] in_a, in_b;
  trap_e      in_trap;
  logic [7:0] res_y;
  logic       res_zero, res_ovf, res_err;

  assign idle   = (state_q == StIdle);
  assign accept = idle && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  ({req1_valid, req0_valid}),
    .en_i   (idle),
    .gnt_o  (gnt)
  );

  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];

  assign in_op   = gnt[1] ? req1_opcode : req0_opcode;
  assign in_a    = gnt[1] ? req1_a : req0_a;
  assign in_b    = gnt[1] ? req1_b : req0_b;
  assign in_trap = op_trap(in_op, in_b);

  // ALU sees the held operands only while a non-trapped op is executing.
  always_comb begin
    alu_opcode = OP_NOP;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    if (state_q == StExec && trap_q == TrapNone) begin
      alu_opcode = op_q;
      alu_a      = a_q;
      alu_b      = b_q;
    end
  end

  // Select the response fields: ALU result or the fixed trap pattern.
  always_comb begin
    res_y    = alu_y;
    res_zero = alu_zero;
    res_ovf  = alu_overflow;
    res_err  = 1'b0;
    unique case (trap_q)
      TrapDiv0: begin
        res_y    = Y_DIV0;
        res_zero = 1'b0;
        res_ovf  = 1'b0;
        res_err  = 1'b1;
      end
      TrapIll: begin
        res_y    = Y_ILL;
        res_zero = 1'b1;
        res_ovf  = 1'b0;
        res_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Scheduler FSM: latch the granted op, count down its hold time, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OP_NOP;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      port_q     <= 1'b0;
      trap_q     <= TrapNone;
      cnt_q      <= 8'h00;
      rsp0_valid <= 1'b0;
      rsp0_y     <= 8'h00;
      rsp0_zero  <= 1'b0;
      rsp0_ovf   <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_y     <= 8'h00;
      rsp1_zero  <= 1'b0;
      rsp1_ovf   <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= in_op;
            a_q     <= in_a;
            b_q     <= in_b;
            port_q  <= gnt[1];
            trap_q  <= in_trap;
            // Trapped ops respond after a single cycle whatever the opcode.
            cnt_q   <= (in_trap != TrapNone) ? 8'h00
                     : op_latency(in_op, 8'(MUL_CYCLES), 8'(DIV_CYCLES)) - 8'd1;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == 8'h00) begin
            if (port_q) begin
              rsp1_valid <= 1'b1;
              rsp1_y     <= res_y;
              rsp1_zero  <= res_zero;
              rsp1_ovf   <= res_ovf;
              rsp1_err   <= res_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_y     <= res_y;
              rsp0_zero  <= res_zero;
              rsp0_ovf   <= res_ovf;
              rsp0_err   <= res_err;
            end
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: drivers push expected responses on accept,
// a negedge monitor pops and compares every response pulse.
module tb_alu_sched;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_zero, rsp0_ovf, rsp0_err;
  logic       rsp1_valid, rsp1_zero, rsp1_ovf, rsp1_err;
  logic [7:0] rsp0_y, rsp1_y;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_zero, alu_overflow;
  logic [15:0] prod;

  typedef struct {
    bit         port;
    logic [7:0] y;
    bit         z;
    bit         o;
    bit         e;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   last_acc[2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_sched #(
    .MUL_CYCLES (2),
    .DIV_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opcode  (req0_opcode),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .rsp0_valid   (rsp0_valid),
    .rsp0_y       (rsp0_y),
    .rsp0_zero    (rsp0_zero),
    .rsp0_ovf     (rsp0_ovf),
    .rsp0_err     (rsp0_err),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opcode  (req1_opcode),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp1_valid   (rsp1_valid),
    .rsp1_y       (rsp1_y),
    .rsp1_zero    (rsp1_zero),
    .rsp1_ovf     (rsp1_ovf),
    .rsp1_err     (rsp1_err),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  // Behavioural ALU: ADD ovf = carry out, SUB ovf = borrow, MUL ovf = high byte nonzero.
  always_comb begin
    alu_y        = 8'h00;
    alu_overflow = 1'b0;
    prod         = 16'h0000;
    case (alu_opcode)
      4'h0: {alu_overflow, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: begin
        alu_y        = alu_a - alu_b;
        alu_overflow = (alu_a < alu_b);
      end
      4'h2: begin
        prod         = alu_a * alu_b;
        alu_y        = prod[7:0];
        alu_overflow = (prod[15:8] != 8'h00);
      end
      4'h3: alu_y = (alu_b != 8'h00) ? alu_a / alu_b : 8'hFF;
      4'h4: alu_y = alu_a & alu_b;
      4'h5: alu_y = alu_a | alu_b;
      4'h6: alu_y = alu_a ^ alu_b;
      4'h7: alu_y = ~alu_a;
      4'h8: alu_y = alu_a << alu_b[2:0];
      4'h9: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = 8'h00;
    endcase
    alu_zero = (alu_y == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input bit v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    if (port) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  // Present one request, wait (bounded) for its accept, record the expected response.
  task automatic issue(input bit port, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ey, input bit ez, input bit eo,
                       input bit ee, input int lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    drive(port, 1'b1, op, a, b);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        e = '{port, ey, ez, eo, ee, lat, cyc + 1};
        sb.push_back(e);
        grant_log.push_back(int'(port));
        last_acc[port] = cyc + 1;
        done = 1'b1;
        @(posedge clk);
        #1;
        drive(port, 1'b0, 4'h0, 8'h00, 8'h00);
      end
    end
    if (!done) begin
      chk("issue_timeout", 32'd0, 32'd1);
      drive(port, 1'b0, 4'h0, 8'h00, 8'h00);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   p;
    if (rst_n && (rsp0_valid || rsp1_valid)) begin
      chk("rsp_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        p = rsp1_valid;
        chk("rsp_port", {31'd0, p}, {31'd0, e.port});
        chk("rsp_latency", cyc, e.acc + e.lat);
        chk("rsp_y", p ? rsp1_y : rsp0_y, e.y);
        chk("rsp_zero", p ? rsp1_zero : rsp0_zero, e.z);
        chk("rsp_ovf", p ? rsp1_ovf : rsp0_ovf, e.o);
        chk("rsp_err", p ? rsp1_err : rsp0_err, e.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu_opcode", alu_opcode, 4'hF);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_ready0", req0_ready, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_rsp0_y", rsp0_y, 0);
    chk("reset_rsp1_err", rsp1_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters issue continuously from reset: grants must alternate 0,1,0,1.
    fork
      begin
        issue(1'b0, OP_ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 1);
        issue(1'b0, OP_XOR, 8'hF0, 8'hFF, 8'h0F, 0, 0, 0, 1);
        issue(1'b0, OP_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 0, 1);
      end
      begin
        issue(1'b1, OP_SUB, 8'h03, 8'h05, 8'hFE, 0, 1, 0, 1);
        issue(1'b1, OP_OR,  8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
        issue(1'b1, OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1);
      end
    join
    chk("grant_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) chk("grant_order", grant_log[i], i % 2);
    drain();

    // ADD on req0: operands on the ALU during EXEC, ready low, later input changes ignored.
    issue(1'b0, OP_ADD, 8'h70, 8'h20, 8'h90, 0, 0, 0, 1);
    drive(1'b0, 1'b1, OP_SHL, 8'h11, 8'h22);
    @(negedge clk);
    chk("add_alu_opcode", alu_opcode, OP_ADD);
    chk("add_alu_a", alu_a, 8'h70);
    chk("add_alu_b", alu_b, 8'h20);
    chk("add_ready0_exec", req0_ready, 0);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("rsp0_y_hold", rsp0_y, 8'h90);

    // DIV 200/7: ALU held 4 cycles, competing request waits until E5.
    issue(1'b0, OP_DIV, 8'd200, 8'd7, 8'd28, 0, 0, 0, 4);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("div_alu_opcode", alu_opcode, OP_DIV);
          chk("div_alu_a", alu_a, 8'd200);
          chk("div_alu_b", alu_b, 8'd7);
          chk("div_ready1_exec", req1_ready, 0);
        end
      end
      issue(1'b1, OP_ADD, 8'h01, 8'hFF, 8'h00, 1, 1, 0, 1);
    join
    chk("div_next_accept", last_acc[1] - last_acc[0], 5);
    drain();

    // Trapped ops never touch the ALU; then a normal MUL.
    issue(1'b1, OP_DIV, 8'd9, 8'd0, Y_DIV0, 0, 0, 1, 1);
    @(negedge clk);
    chk("div0_alu_idle", alu_opcode, 4'hF);
    issue(1'b1, 4'hC, 8'h01, 8'h02, Y_ILL, 1, 0, 1, 1);
    @(negedge clk);
    chk("ill_alu_idle", alu_opcode, 4'hF);
    issue(1'b0, OP_MUL, 8'd12, 8'd10, 8'h78, 0, 0, 0, 2);
    drain();

    // Reset mid-MUL: in-flight op dropped, outputs back to reset values.
    drive(1'b0, 1'b1, OP_MUL, 8'd3, 8'd4);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    chk("mul_accept", {31'd0, ok}, 1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    chk("mul_alu_opcode", alu_opcode, OP_MUL);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_alu_opcode", alu_opcode, 4'hF);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp0_y", rsp0_y, 0);
    chk("rst_rsp1_zero", rsp1_zero, 0);
    chk("rst_rsp1_err", rsp1_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // After reset requester 0 wins the tie again.
    grant_log.delete();
    fork
      issue(1'b0, OP_ADD, 8'h10, 8'h01, 8'h11, 0, 0, 0, 1);
      issue(1'b1, OP_ADD, 8'h20, 8'h02, 8'h22, 0, 0, 0, 1);
    join
    chk("tie_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("tie_first", grant_log[0], 0);
      chk("tie_second", grant_log[1], 1);
    end
    drain();
    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
